// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO ownership for the MIPS E stage.
// One radix-2 iteration per cycle; stalls the pipeline until HI/LO are committed.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, stateNext;
    logic [CW-1:0]      cnt;
    logic               isDiv, sa, sb, divZero;
    logic [WIDTH-1:0]   opnd, aOrig;
    logic [2*WIDTH-1:0] acc, accNext, prod;
    logic [WIDTH-1:0]   absA, absB, quot, rem;
    logic [WIDTH:0]     mulSum, divTmp, divDiff;
    logic               divOk;
    logic               accept, lastIter, commit;

    assign accept   = (state == IDLE) && start && !cancel;
    assign lastIter = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign commit   = lastIter && !cancel;
    assign stall    = accept || ((state == RUN) && !cancel);

    assign absA = (op[0] && a[WIDTH-1]) ? -a : a;
    assign absB = (op[0] && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = RUN;
            RUN:     if (cancel || lastIter) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
    always_comb begin
        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        divTmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff = divTmp - {1'b0, opnd};
        divOk   = !divDiff[WIDTH];
        if (isDiv)
            accNext = {divOk ? divDiff[WIDTH-1:0] : divTmp[WIDTH-1:0], acc[WIDTH-2:0], divOk};
        else
            accNext = {mulSum, acc[WIDTH-1:1]};
        prod = (sa ^ sb) ? -accNext : accNext;
        quot = (sa ^ sb) ? -accNext[WIDTH-1:0] : accNext[WIDTH-1:0];
        rem  = sa ? -accNext[2*WIDTH-1:WIDTH] : accNext[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            aOrig   <= '0;
            isDiv   <= 1'b0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            divZero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= commit;
            if (state == IDLE) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
                if (accept) begin
                    isDiv   <= op[1];
                    sa      <= a[WIDTH-1] & op[0];
                    sb      <= b[WIDTH-1] & op[0];
                    aOrig   <= a;
                    divZero <= (b == '0);
                    cnt     <= '0;
                    // Upper half starts cleared; lower half holds the bits consumed per step.
                    acc     <= {{WIDTH{1'b0}}, op[1] ? absA : absB};
                    opnd    <= op[1] ? absB : absA;
                end
            end else if (!cancel) begin
                cnt <= cnt + CW'(1);
                acc <= accNext;
                if (lastIter) begin
                    if (!isDiv) begin
                        {hi, lo} <= prod;
                    end else if (divZero) begin
                        hi <= aOrig;
                        lo <= '1;
                    end else begin
                        hi <= rem;
                        lo <= quot;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level behavioural model plus directed literal checks.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        cancel = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        stall, done;
    logic [31:0] hi, lo;

    int nChecks = 0;
    int nFails  = 0;
    bit chkEn   = 1'b0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] modelRes(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ux;
        longint sx, sy, q, r, p;
        ux = {32'b0, x};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: return ux * {32'b0, y};
            2'b01: begin p = sx * sy; return p; end
            2'b10: if (y == 0) return {x, 32'hFFFF_FFFF};
                   else return {x % y, x / y};
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Cycle model: an accepted op commits 32 cycles after the accept edge unless cancelled.
    logic        mBusy = 1'b0, mDone = 1'b0;
    int          mLeft = 0;
    logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;

    always @(posedge clk) begin
        if (rst) begin
            mBusy <= 1'b0; mDone <= 1'b0; mHi <= '0; mLo <= '0;
        end else begin
            mDone <= 1'b0;
            if (!mBusy) begin
                if (mthi) mHi <= wdata;
                if (mtlo) mLo <= wdata;
                if (start && !cancel) begin
                    mBusy <= 1'b1;
                    mLeft <= 32;
                    {pHi, pLo} <= modelRes(op, a, b);
                end
            end else if (cancel) begin
                mBusy <= 1'b0;
            end else if (mLeft == 1) begin
                mBusy <= 1'b0;
                mHi   <= pHi;
                mLo   <= pLo;
                mDone <= 1'b1;
            end else begin
                mLeft <= mLeft - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            chk("stall", {31'b0, stall}, {31'b0, (!mBusy && start && !cancel) || (mBusy && !cancel)});
            chk("done",  {31'b0, done},  {31'b0, mDone});
            chk("hi", hi, mHi);
            chk("lo", lo, mLo);
        end
    end

    // Present an op in the current cycle and return #1 into cycle 33.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit noise, input int cancelAt);
        bit cut = 1'b0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        for (int c = 1; c <= 32; c++) begin
            cancel = (c == cancelAt);
            if (cancel) cut = 1'b1;
            if (noise && !cut) begin
                start = ($urandom_range(3) == 0);
                op    = 2'($urandom_range(3));
                a     = $urandom;
                b     = $urandom;
                mthi  = ($urandom_range(7) == 0);
                mtlo  = ($urandom_range(7) == 0);
                wdata = $urandom;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        chkEn = 1'b1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        runOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        chk("multu_done", {31'b0, done}, 32'h1);
        chk("multu_stall33", {31'b0, stall}, 32'h0);
        runOp(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        runOp(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        runOp(2'b10, 32'h1234_5678, 32'd0, 1'b0, 0);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'h1234_5678);
        runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);
        @(posedge clk); #1;

        mthi = 1'b1; wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mthi", hi, 32'hAAAA_5555);
        chk("mtlo", lo, 32'h0000_1234);
        runOp(2'b10, 32'd100, 32'd7, 1'b0, 10);
        chk("cancel_hi", hi, 32'hAAAA_5555);
        chk("cancel_lo", lo, 32'h0000_1234);

        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        runOp(2'b00, 32'd6, 32'd7, 1'b0, 0);
        chk("restart_lo", lo, 32'd42);
        chk("restart_hi", hi, 32'd0);
        runOp(2'b10, 32'd100, 32'd7, 1'b1, 0);
        chk("b2b_lo", lo, 32'd14);
        chk("b2b_hi", hi, 32'd2);
        chk("b2b_done", {31'b0, done}, 32'h1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(3) == 0) rb = rb >> $urandom_range(31);
            mthi  = ($urandom_range(3) == 0);
            mtlo  = ($urandom_range(3) == 0);
            wdata = $urandom;
            runOp(2'($urandom_range(3)), ra, rb, 1'b1,
                  ($urandom_range(7) == 0) ? int'($urandom_range(32, 1)) : 0);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
